lut_neuron_layer: RTL and testbench

- Parametrised, runtime-programmable LUT neuron layer: N_NEURONS independent truth-table neurons, each mapping its own IN_BITS input slice to an OUT_BITS output.
- Replaces fixed per-neuron case-table modules with one block whose tables load through a config port.
- Sits between layer input registers and the next layer.
- Valid/ready streaming, 2-cycle latency, full throughput.

---
 rtl/lut_neuron_layer.sv | 152 +++++++++++++++
 tb/tb_lut_neuron_layer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_layer.sv
// rtl/lut_neuron_layer.sv - runtime-programmable LUT neuron layer, 2-stage valid/ready pipeline
// Optional entry parity storage and sticky parity_err port under `define LUT_PARITY_EN.
module lut_neuron_layer #(
  parameter int N_NEURONS = 8,
  parameter int IN_BITS   = 6,
  parameter int OUT_BITS  = 1,
  parameter int NSEL_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                          cfg_we,
  input  logic [NSEL_W-1:0]             cfg_neuron,
  input  logic [IN_BITS-1:0]            cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  output logic                          init_done
`ifdef LUT_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int DEPTH = 1 << IN_BITS;
`ifdef LUT_PARITY_EN
  localparam int ENT_W = OUT_BITS + 1;
`else
  localparam int ENT_W = OUT_BITS;
`endif

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                          state_q, state_d;
  logic [IN_BITS-1:0]              clr_cnt_q, clr_cnt_d;
  logic                            init_done_q, init_done_d;
  logic                            s1_valid_q, s1_valid_d;
  logic [N_NEURONS*IN_BITS-1:0]    s1_data_q, s1_data_d;
  logic                            out_valid_q, out_valid_d;
  logic [N_NEURONS*OUT_BITS-1:0]   out_data_q, out_data_d;
  logic [ENT_W-1:0]                table_q [N_NEURONS][DEPTH];
  logic [ENT_W-1:0]                table_d [N_NEURONS][DEPTH];
  logic [ENT_W-1:0]                cfg_entry;
  logic [ENT_W-1:0]                ent;
  logic [N_NEURONS*OUT_BITS-1:0]   lookup;
  logic                            advance;
`ifdef LUT_PARITY_EN
  logic                            perr;
  logic                            parity_err_q, parity_err_d;

  assign cfg_entry  = {^cfg_data, cfg_data};
  assign parity_err = parity_err_q;
`else
  assign cfg_entry  = cfg_data;
`endif

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = (state_q == S_RUN) && advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign init_done = init_done_q;

  // Table clear sweeps one entry of every neuron per cycle; config writes only land in RUN.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    table_d     = table_q;
    if (!rst) begin
      if (state_q == S_INIT) begin
        for (int n = 0; n < N_NEURONS; n++) begin
          table_d[n][clr_cnt_q] = '0;
        end
        clr_cnt_d = clr_cnt_q + IN_BITS'(1);
        if (clr_cnt_q == IN_BITS'(DEPTH - 1)) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end else if (cfg_we && (int'(cfg_neuron) < N_NEURONS)) begin
        table_d[cfg_neuron][cfg_addr] = cfg_entry;
      end
    end
  end

  // Reads the registered table, so a write on the same edge is not yet visible.
  always_comb begin
    lookup = '0;
    ent    = '0;
`ifdef LUT_PARITY_EN
    perr   = 1'b0;
`endif
    for (int n = 0; n < N_NEURONS; n++) begin
      ent = table_q[n][s1_data_q[n*IN_BITS +: IN_BITS]];
      lookup[n*OUT_BITS +: OUT_BITS] = ent[OUT_BITS-1:0];
`ifdef LUT_PARITY_EN
      perr = perr | (^ent);
`endif
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef LUT_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (advance) begin
      s1_valid_d  = in_valid && in_ready;
      if (in_valid && in_ready) s1_data_d = in_data;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = lookup;
`ifdef LUT_PARITY_EN
        parity_err_d = parity_err_q | perr;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    table_q <= table_d;
    if (rst) begin
      state_q     <= S_INIT;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef LUT_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef LUT_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_lut_neuron_layer.sv
// tb/tb_lut_neuron_layer.sv - scoreboard bench for lut_neuron_layer
// A second small instance (6 neurons) exercises out-of-range neuron selects.
module tb_lut_neuron_layer;
  localparam int N = 8, IB = 6, OB = 1, NSEL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, out_valid, out_ready, cfg_we, init_done;
  logic [N*IB-1:0] in_data;
  logic [N*OB-1:0] out_data;
  logic [NSEL-1:0] cfg_neuron;
  logic [IB-1:0]   cfg_addr;
  logic [OB-1:0]   cfg_data;

  logic        in_valid2, in_ready2, out_valid2, cfg_we2, init_done2;
  logic [11:0] in_data2;
  logic [5:0]  out_data2;
  logic [2:0]  cfg_neuron2;
  logic [1:0]  cfg_addr2;
  logic [0:0]  cfg_data2;
`ifdef LUT_PARITY_EN
  logic parity_err, parity_err2;
`endif

  lut_neuron_layer #(.N_NEURONS(N), .IN_BITS(IB), .OUT_BITS(OB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .cfg_we(cfg_we),
    .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .init_done(init_done)
`ifdef LUT_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  lut_neuron_layer #(.N_NEURONS(6), .IN_BITS(2), .OUT_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2), .cfg_we(cfg_we2),
    .cfg_neuron(cfg_neuron2), .cfg_addr(cfg_addr2), .cfg_data(cfg_data2), .init_done(init_done2)
`ifdef LUT_PARITY_EN
    , .parity_err(parity_err2)
`endif
  );

  int checks = 0, errors = 0, stalls = 0, cyc = 0;
  logic [N*OB-1:0] exp_q[$];
  int pop_cyc[$];
  bit model [N][64];
  logic [IB-1:0] prog_addr [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake and polices stalls.
  logic stall_prev = 1'b0;
  logic [N*OB-1:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_data", out_data, held);
        chk("hold_valid", out_valid, 1);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      stall_prev = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          chk("out_data", out_data, exp_q.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  function automatic logic [N*OB-1:0] model_out(input logic [N*IB-1:0] d);
    logic [N*OB-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++) r[n] = model[n][d[n*IB +: IB]];
    return r;
  endfunction

  function automatic logic [N*IB-1:0] rand_vec();
    logic [N*IB-1:0] r;
    for (int n = 0; n < N; n++)
      r[n*IB +: IB] = ($urandom_range(0, 1) == 1) ? prog_addr[n] : IB'($urandom_range(0, 63));
    return r;
  endfunction

  task automatic send(input logic [N*IB-1:0] d, input logic [N*OB-1:0] e);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (w >= 100) chk("send_timeout", 0, 1);
    stalls += w;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_cfg(input int n, input logic [IB-1:0] a, input logic [OB-1:0] v);
    cfg_we = 1'b1; cfg_neuron = NSEL'(n); cfg_addr = a; cfg_data = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model[n][a] = v[0];
  endtask

  task automatic wait_init();
    int bad;
    bad = 0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (i < 64) begin
        if (in_ready !== 1'b0 || init_done !== 1'b0) bad++;
      end else begin
        chk("ready_at_64", in_ready, 1);
        chk("init_done_at_64", init_done, 1);
      end
    end
    chk("init_low_63_cycles", bad, 0);
  endtask

  initial begin
    logic [N*IB-1:0] d;
    int base;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    in_valid2 = 1'b0; in_data2 = '0; cfg_we2 = 1'b0; cfg_neuron2 = '0; cfg_addr2 = '0; cfg_data2 = '0;
    for (int n = 0; n < N; n++) for (int a = 0; a < 64; a++) model[n][a] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_init_done", init_done, 0);
`ifdef LUT_PARITY_EN
    chk("rst_parity_err", parity_err, 0);
`endif

    // Config write held across INIT must be ignored.
    rst = 1'b0;
    cfg_we = 1'b1; cfg_neuron = 3'd0; cfg_addr = 6'h3f; cfg_data = 1'b1;
    wait_init();
    cfg_we = 1'b0;
    send({N{6'h3f}}, 8'h00);
    drain();

    do_cfg(0, 6'h10, 1'b1);
    do_cfg(3, 6'h01, 1'b1);
    d = '0; d[0 +: IB] = 6'h10; d[3*IB +: IB] = 6'h01;
    send(d, 8'b0000_1001);
    chk("lat_after_edge1", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_after_edge2", out_valid, 1);
    chk("lat_data", out_data, 8'b0000_1001);
    drain();

    for (int n = 0; n < N; n++) begin
      prog_addr[n] = IB'($urandom_range(8, 63));
      do_cfg(n, prog_addr[n], 1'b1);
    end
    stalls = 0;
    base = pop_cyc.size();
    for (int i = 0; i < 16; i++) begin
      d = rand_vec();
      send(d, model_out(d));
    end
    drain();
    chk("stream_in_ready_stalls", stalls, 0);
    chk("stream_consecutive", pop_cyc[base+15] - pop_cyc[base], 15);

    // Backpressure: freeze with a full pipeline and a pending input.
    for (int i = 0; i < 3; i++) begin
      d = rand_vec();
      send(d, model_out(d));
    end
    out_ready = 1'b0;
    d = rand_vec();
    in_valid = 1'b1; in_data = d;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    send(d, model_out(d));
    for (int i = 0; i < 2; i++) begin
      d = rand_vec();
      send(d, model_out(d));
    end
    drain();

    // Write lands on the same edge stage 2 reads entry 0x05 of neuron 2.
    d = '0; d[2*IB +: IB] = 6'h05;
    send(d, 8'h00);
    cfg_we = 1'b1; cfg_neuron = 3'd2; cfg_addr = 6'h05; cfg_data = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model[2][5] = 1'b1;
    drain();
    send(d, 8'h04);
    drain();

    chk("dut2_init_done", init_done2, 1);
    cfg_we2 = 1'b1; cfg_neuron2 = 3'd7; cfg_addr2 = 2'd0; cfg_data2 = 1'b1;
    @(posedge clk); #1;
    cfg_neuron2 = 3'd5;
    @(posedge clk); #1;
    cfg_we2 = 1'b0;
    in_valid2 = 1'b1; in_data2 = '0;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    chk("nsel_range_valid", out_valid2, 1);
    chk("nsel_range_data", out_data2, 6'b100000);

`ifdef LUT_PARITY_EN
    chk("parity_clean", parity_err, 0);
    dut.table_q[1][7][0] = ~dut.table_q[1][7][0];
    d = '0; d[IB +: IB] = 6'd7;
    send(d, model_out(d) ^ 8'h02);
    drain();
    chk("parity_err_set", parity_err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("parity_err_sticky", parity_err, 1);
`endif

    // Reset with two vectors in flight.
    out_ready = 1'b0;
    send(rand_vec(), 8'h00);
    send(rand_vec(), 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_init_done", init_done, 0);
`ifdef LUT_PARITY_EN
    chk("midrst_parity_err", parity_err, 0);
`endif
    exp_q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < N; n++) for (int a = 0; a < 64; a++) model[n][a] = 1'b0;
    wait_init();
    d = '0; d[0 +: IB] = 6'h10; d[2*IB +: IB] = 6'h05; d[3*IB +: IB] = 6'h01;
    send(d, 8'h00);
    d = '0;
    for (int n = 0; n < N; n++) d[n*IB +: IB] = prog_addr[n];
    send(d, 8'h00);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
